// File: rtl/axis_bus_demux.sv
// AXI-Stream 1:2 packet demultiplexer. The destination is decoded from bus_sel on the
// first beat of each packet. Routed beats pass through one shared, port-tagged output register.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for the first beat of a packet (bus_sel is decoded)
// ROUTE0 | packet in progress, beats go to output 0
// ROUTE1 | packet in progress, beats go to output 1
// DROP   | packet in progress, beats are accepted and discarded
module axis_bus_demux #(
  parameter logic [7:0] CHOOSE_FIFO_0 = 8'd128,
  parameter logic [7:0] CHOOSE_FIFO_1 = 8'd129
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  bus_sel,

  input  logic        axis_in_tvalid,
  output logic        axis_in_tready,
  input  logic [31:0] axis_in_tdata,
  input  logic [3:0]  axis_in_tkeep,
  input  logic        axis_in_tlast,

  output logic        axis_out_0_tvalid,
  input  logic        axis_out_0_tready,
  output logic [31:0] axis_out_0_tdata,
  output logic [3:0]  axis_out_0_tkeep,
  output logic        axis_out_0_tlast,

  output logic        axis_out_1_tvalid,
  input  logic        axis_out_1_tready,
  output logic [31:0] axis_out_1_tdata,
  output logic [3:0]  axis_out_1_tkeep,
  output logic        axis_out_1_tlast,

  output logic        busy,
  output logic [7:0]  drop_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ROUTE0 = 2'd1;
  localparam logic [1:0] ST_ROUTE1 = 2'd2;
  localparam logic [1:0] ST_DROP   = 2'd3;

  localparam logic [1:0] TGT_OUT0 = 2'd0;
  localparam logic [1:0] TGT_OUT1 = 2'd1;
  localparam logic [1:0] TGT_DROP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        live_q;
  logic        reg_valid_q, reg_valid_d;
  logic        reg_port_q, reg_port_d;
  logic [31:0] reg_data_q, reg_data_d;
  logic [3:0]  reg_keep_q, reg_keep_d;
  logic        reg_last_q, reg_last_d;
  logic [7:0]  drop_cnt_q, drop_cnt_d;

  logic [1:0]  tgt;
  logic        tgt_drop;
  logic        tag_ready;
  logic        in_ready;
  logic        in_fire;
  logic        load;
  logic        drain;

  // Destination of the beat currently offered on the input.
  always_comb begin
    tgt = TGT_DROP;
    case (state_q)
      ST_IDLE: begin
        if (bus_sel == CHOOSE_FIFO_0)      tgt = TGT_OUT0;
        else if (bus_sel == CHOOSE_FIFO_1) tgt = TGT_OUT1;
        else                               tgt = TGT_DROP;
      end
      ST_ROUTE0: tgt = TGT_OUT0;
      ST_ROUTE1: tgt = TGT_OUT1;
      default:   tgt = TGT_DROP;
    endcase
  end

  assign tgt_drop = (tgt == TGT_DROP);

  // Only the tagged port's tready is looked at, so the idle port cannot stall the input.
  assign tag_ready = reg_port_q ? axis_out_1_tready : axis_out_0_tready;
  assign drain     = reg_valid_q & tag_ready;
  assign in_ready  = live_q & (tgt_drop | ~reg_valid_q | tag_ready);
  assign in_fire   = axis_in_tvalid & in_ready;
  assign load      = in_fire & ~tgt_drop;

  // Load wins over drain, so a beat for the other port can follow without a bubble.
  always_comb begin
    reg_valid_d = reg_valid_q;
    reg_port_d  = reg_port_q;
    reg_data_d  = reg_data_q;
    reg_keep_d  = reg_keep_q;
    reg_last_d  = reg_last_q;
    if (load) begin
      reg_valid_d = 1'b1;
      reg_port_d  = tgt[0];
      reg_data_d  = axis_in_tdata;
      reg_keep_d  = axis_in_tkeep;
      reg_last_d  = axis_in_tlast;
    end else if (drain) begin
      reg_valid_d = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (in_fire) begin
      if (state_q == ST_IDLE) begin
        if (!axis_in_tlast) begin
          case (tgt)
            TGT_OUT0: state_d = ST_ROUTE0;
            TGT_OUT1: state_d = ST_ROUTE1;
            default:  state_d = ST_DROP;
          endcase
        end
      end else if (axis_in_tlast) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (in_fire && tgt_drop && axis_in_tlast && (drop_cnt_q != 8'hFF))
      drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      live_q      <= 1'b0;
      reg_valid_q <= 1'b0;
      reg_port_q  <= 1'b0;
      reg_data_q  <= 32'd0;
      reg_keep_q  <= 4'd0;
      reg_last_q  <= 1'b0;
      drop_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      reg_valid_q <= reg_valid_d;
      reg_port_q  <= reg_port_d;
      reg_data_q  <= reg_data_d;
      reg_keep_q  <= reg_keep_d;
      reg_last_q  <= reg_last_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  logic sel0, sel1;
  assign sel0 = reg_valid_q & ~reg_port_q;
  assign sel1 = reg_valid_q &  reg_port_q;

  assign axis_in_tready    = in_ready;

  assign axis_out_0_tvalid = sel0;
  assign axis_out_0_tdata  = sel0 ? reg_data_q : 32'd0;
  assign axis_out_0_tkeep  = sel0 ? reg_keep_q : 4'd0;
  assign axis_out_0_tlast  = sel0 & reg_last_q;

  assign axis_out_1_tvalid = sel1;
  assign axis_out_1_tdata  = sel1 ? reg_data_q : 32'd0;
  assign axis_out_1_tkeep  = sel1 ? reg_keep_q : 4'd0;
  assign axis_out_1_tlast  = sel1 & reg_last_q;

  assign busy     = (state_q != ST_IDLE);
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_axis_bus_demux.sv
// Bench for axis_bus_demux: a queue-based packet model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_axis_bus_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  bus_sel = 8'd0;
  logic        axis_in_tvalid = 1'b0;
  logic        axis_in_tready;
  logic [31:0] axis_in_tdata = 32'd0;
  logic [3:0]  axis_in_tkeep = 4'd0;
  logic        axis_in_tlast = 1'b0;
  logic        axis_out_0_tvalid, axis_out_1_tvalid;
  logic        axis_out_0_tready = 1'b0, axis_out_1_tready = 1'b0;
  logic [31:0] axis_out_0_tdata, axis_out_1_tdata;
  logic [3:0]  axis_out_0_tkeep, axis_out_1_tkeep;
  logic        axis_out_0_tlast, axis_out_1_tlast;
  logic        busy;
  logic [7:0]  drop_cnt;

  axis_bus_demux dut (
    .clk(clk), .rst_n(rst_n), .bus_sel(bus_sel),
    .axis_in_tvalid(axis_in_tvalid), .axis_in_tready(axis_in_tready),
    .axis_in_tdata(axis_in_tdata), .axis_in_tkeep(axis_in_tkeep), .axis_in_tlast(axis_in_tlast),
    .axis_out_0_tvalid(axis_out_0_tvalid), .axis_out_0_tready(axis_out_0_tready),
    .axis_out_0_tdata(axis_out_0_tdata), .axis_out_0_tkeep(axis_out_0_tkeep),
    .axis_out_0_tlast(axis_out_0_tlast),
    .axis_out_1_tvalid(axis_out_1_tvalid), .axis_out_1_tready(axis_out_1_tready),
    .axis_out_1_tdata(axis_out_1_tdata), .axis_out_1_tkeep(axis_out_1_tkeep),
    .axis_out_1_tlast(axis_out_1_tlast),
    .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int decode(input logic [7:0] s);
    if (s == 8'd128) return 0;
    if (s == 8'd129) return 1;
    return 2;
  endfunction

  // Model: beats accepted for an output but not yet taken downstream, in order.
  typedef struct packed {
    logic        port;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t q[$];
  bit    m_inpkt;
  int    m_dest;
  int    m_drop;
  bit    m_live;
  int    out_cnt[2];
  bit    h0, h1;
  int    md;
  beat_t mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_inpkt = 0;
      m_dest  = 0;
      m_drop  = 0;
      m_live  = 0;
    end else begin
      h0 = axis_out_0_tvalid && axis_out_0_tready;
      h1 = axis_out_1_tvalid && axis_out_1_tready;
      if (h0 || h1) begin
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          out_cnt[h1 ? 1 : 0]++;
          void'(q.pop_front());
        end
      end
      if (axis_in_tvalid && axis_in_tready) begin
        md = m_inpkt ? m_dest : decode(bus_sel);
        if (md == 2) begin
          if (axis_in_tlast && m_drop < 255) m_drop++;
        end else begin
          mb.port = md[0];
          mb.data = axis_in_tdata;
          mb.keep = axis_in_tkeep;
          mb.last = axis_in_tlast;
          q.push_back(mb);
        end
        if (!m_inpkt && !axis_in_tlast) begin
          m_inpkt = 1;
          m_dest  = md;
        end else if (m_inpkt && axis_in_tlast) begin
          m_inpkt = 0;
        end
      end
      m_live = 1;
    end
  end

  logic [37:0] e0, e1;
  logic        et, hr;
  int          cd;

  always @(negedge clk) begin
    e0 = '0;
    e1 = '0;
    hr = 1'b1;
    if (q.size() > 1) check("reg_depth", q.size(), 1);
    if (q.size() > 0) begin
      if (q[0].port) e1 = {1'b1, q[0].data, q[0].keep, q[0].last};
      else           e0 = {1'b1, q[0].data, q[0].keep, q[0].last};
      hr = q[0].port ? axis_out_1_tready : axis_out_0_tready;
    end
    cd = m_inpkt ? m_dest : decode(bus_sel);
    et = m_live && (cd == 2 || hr);
    check("out0", {axis_out_0_tvalid, axis_out_0_tdata, axis_out_0_tkeep, axis_out_0_tlast}, e0);
    check("out1", {axis_out_1_tvalid, axis_out_1_tdata, axis_out_1_tkeep, axis_out_1_tlast}, e1);
    check("in_tready", axis_in_tready, et);
    check("busy", busy, m_inpkt);
    check("drop_cnt", drop_cnt, m_drop);
  end

  task automatic send(input logic [7:0] sel, input logic [31:0] data, input logic [3:0] keep,
                      input logic last, output int waits);
    bit acc;
    bus_sel        = sel;
    axis_in_tdata  = data;
    axis_in_tkeep  = keep;
    axis_in_tlast  = last;
    axis_in_tvalid = 1'b1;
    waits = 0;
    forever begin
      @(negedge clk);
      acc = axis_in_tready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 100) begin
        check("send_timeout", waits, 0);
        break;
      end
    end
    axis_in_tvalid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  int w, wsum, c0, c1;

  initial begin
    // Reset state
    @(negedge clk);
    check("rst_out0_valid", axis_out_0_tvalid, 0);
    check("rst_in_tready", axis_in_tready, 0);
    check("rst_busy", busy, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    axis_out_0_tready = 1'b1;
    axis_out_1_tready = 1'b1;

    // Single-beat route to out0
    send(8'd128, 32'hA5A5_0001, 4'hF, 1'b1, w);
    @(negedge clk);
    check("single_out0_valid", axis_out_0_tvalid, 1);
    check("single_out0_data", axis_out_0_tdata, 32'hA5A5_0001);
    check("single_out1_valid", axis_out_1_tvalid, 0);
    check("single_busy", busy, 0);
    @(posedge clk); #1;

    // Mid-packet bus_sel change is ignored
    c0 = out_cnt[0]; c1 = out_cnt[1];
    send(8'd129, 32'h1111_0000, 4'hF, 1'b0, w);
    send(8'd129, 32'h1111_0001, 4'h3, 1'b0, w);
    send(8'd128, 32'h1111_0002, 4'hF, 1'b0, w);
    send(8'd128, 32'h1111_0003, 4'h1, 1'b1, w);
    repeat (3) @(posedge clk); #1;
    check("selchg_out1_beats", out_cnt[1] - c1, 4);
    check("selchg_out0_beats", out_cnt[0] - c0, 0);

    // Backpressure on out1 for 5 cycles
    c1 = out_cnt[1];
    send(8'd129, 32'h2222_0000, 4'hF, 1'b0, w);
    axis_out_1_tready = 1'b0;
    fork
      begin
        send(8'd129, 32'h2222_0001, 4'hF, 1'b0, w);
        check("bp_stall_cycles", w, 5);
        send(8'd129, 32'h2222_0002, 4'hF, 1'b0, w);
        send(8'd129, 32'h2222_0003, 4'hF, 1'b1, w);
      end
      begin
        repeat (5) @(posedge clk);
        #1 axis_out_1_tready = 1'b1;
      end
    join
    repeat (3) @(posedge clk); #1;
    check("bp_out1_beats", out_cnt[1] - c1, 4);

    // Drop packet, then saturation
    wsum = 0;
    send(8'h05, 32'h3333_0000, 4'hF, 1'b0, w); wsum += w;
    send(8'h05, 32'h3333_0001, 4'hF, 1'b0, w); wsum += w;
    send(8'd128, 32'h3333_0002, 4'hF, 1'b1, w); wsum += w;
    check("drop_no_stall", wsum, 0);
    @(negedge clk);
    check("drop_cnt_one", drop_cnt, 8'd1);
    @(posedge clk); #1;
    for (int i = 0; i < 256; i++) send(8'h05, i, 4'hF, 1'b1, w);
    @(negedge clk);
    check("drop_cnt_sat", drop_cnt, 8'hFF);
    @(posedge clk); #1;

    // Back-to-back ports with stalled last beat on out0
    send(8'd128, 32'h4444_0000, 4'hF, 1'b0, w);
    axis_out_0_tready = 1'b0;
    fork
      begin
        send(8'd128, 32'h4444_0001, 4'hF, 1'b1, w);
        check("b2b_out0_stall", w, 3);
        send(8'd129, 32'h4444_0002, 4'hF, 1'b1, w);
        check("b2b_out1_nowait", w, 0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 axis_out_0_tready = 1'b1;
      end
    join
    wsum = 0;
    for (int i = 0; i < 4; i++) begin
      send((i % 2) ? 8'd129 : 8'd128, 32'h5555_0000 + i, 4'hF, 1'b1, w);
      wsum += w;
    end
    check("b2b_no_bubble", wsum, 0);
    repeat (3) @(posedge clk); #1;

    // Mid-packet reset
    send(8'd129, 32'h6666_0000, 4'hF, 1'b0, w);
    send(8'd129, 32'h6666_0001, 4'hF, 1'b0, w);
    bus_sel = 8'd129; axis_in_tdata = 32'h6666_0002; axis_in_tlast = 1'b0; axis_in_tvalid = 1'b1;
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("mrst_out0_valid", axis_out_0_tvalid, 0);
    check("mrst_out1_valid", axis_out_1_tvalid, 0);
    check("mrst_out1_data", axis_out_1_tdata, 0);
    check("mrst_busy", busy, 0);
    check("mrst_in_tready", axis_in_tready, 0);
    check("mrst_drop_cnt", drop_cnt, 0);
    @(posedge clk); #1;
    axis_in_tvalid = 1'b0;
    rst_n = 1'b1;
    send(8'd128, 32'h7777_0000, 4'hF, 1'b1, w);
    @(negedge clk);
    check("mrst_new_out0_valid", axis_out_0_tvalid, 1);
    check("mrst_new_out0_data", axis_out_0_tdata, 32'h7777_0000);
    check("mrst_new_out1_valid", axis_out_1_tvalid, 0);
    repeat (4) @(posedge clk); #1;
    check("final_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axis_bus_demux.md
AXIS_BUS_DEMUX -- requirements
Module: axis_bus_demux

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named clk and rst_n.
REQ-002 The block SHALL provide the following parameters:
- CHOOSE_FIFO_0, default 8'd128, bus_sel code that routes to output 0.
- CHOOSE_FIFO_1, default 8'd129, bus_sel code that routes to output 1.
REQ-003 The block SHALL provide the following ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- bus_sel, input, 8, destination code, sampled only on the first beat of a packet.
- axis_in_tvalid, input, 1, input beat valid.
- axis_in_tready, output, 1, input beat accepted.
- axis_in_tdata, input, 32, input data.
- axis_in_tkeep, input, 4, input byte enables.
- axis_in_tlast, input, 1, last beat of packet.
- axis_out_N_tvalid, output, 1, N=0,1.
- axis_out_N_tready, input, 1, N=0,1.
- axis_out_N_tdata, output, 32, N=0,1.
- axis_out_N_tkeep, output, 4, N=0,1.
- axis_out_N_tlast, output, 1, N=0,1.
- busy, output, 1, packet in progress (state is not IDLE).
- drop_cnt, output, 8, count of dropped packets, saturating.

Function
REQ-004 A beat SHALL transfer on any interface when tvalid and tready are both high at a rising clk edge.
REQ-005 The block SHALL implement the FSM states IDLE, ROUTE0, ROUTE1 and DROP.
REQ-006 In IDLE, an accepted beat SHALL decode bus_sel:
- CHOOSE_FIFO_0 targets output 0.
- CHOOSE_FIFO_1 targets output 1.
- Any other value targets DROP.
REQ-007 In IDLE, an accepted first beat with tlast=0 SHALL move the FSM to ROUTE0, ROUTE1 or DROP according to the decode.
REQ-008 In IDLE, an accepted first beat with tlast=1 SHALL keep the FSM in IDLE; the beat is still routed or dropped.
REQ-009 In ROUTEn or DROP, bus_sel SHALL be ignored, and an accepted beat with tlast=1 SHALL return the FSM to IDLE.
REQ-010 Routed beats SHALL pass through a single shared output register holding data, keep, last and a port tag (reg_valid, reg_port).
REQ-011 The output register SHALL drive axis_out_[reg_port]_* only; the other port's tvalid SHALL be 0 and its data/keep/last SHALL be 0.
REQ-012 Latency SHALL be exactly 1 cycle from input acceptance to output tvalid.
REQ-013 The register SHALL sustain 1 beat/cycle while the target tready stays high.
REQ-014 For routed beats, axis_in_tready SHALL be (!reg_valid || axis_out_[reg_port]_tready).
REQ-015 axis_in_tready SHALL have no combinational dependency on the tready of the non-tagged port.
REQ-016 For beats decoded or held as DROP, axis_in_tready SHALL be 1, and the output register SHALL be left untouched.
REQ-017 On a simultaneous drain of the register and load of a new beat, the register SHALL take the new beat, even if the new beat's port differs.
REQ-018 An output beat SHALL be held stable while its tvalid=1 and tready=0.
REQ-019 A routed beat accepted to the register SHALL never be discarded.
REQ-020 drop_cnt SHALL increment by 1 when a dropped beat with tlast=1 is accepted.
REQ-021 drop_cnt SHALL saturate at 8'hFF.
REQ-022 busy SHALL be 1 whenever the state is not IDLE.

Reset
REQ-023 While rst_n=0, asynchronously:
- state=IDLE.
- reg_valid=0, reg_port=0.
- All axis_out_N_* = 0.
- axis_in_tready=0.
- busy=0.
- drop_cnt=0.
REQ-024 Reset asserted mid-packet SHALL abandon the packet.
REQ-025 After rst_n deasserts, the next accepted beat SHALL be treated as a first beat.
REQ-026 axis_in_tready SHALL be driven 1 from the first clk edge after deassertion.

Verification
REQ-027 The bench SHALL cover the following scenarios:
- Single-beat route: bus_sel=128, one beat data=32'hA5A5_0001, keep=4'hF, last=1, out0 ready=1 -> next cycle out0 tvalid=1 with the same data; out1 tvalid=0; busy stays 0.
- Mid-packet select change: 4-beat packet, bus_sel=129 on beat 0, then changed to 128 on beat 2 -> all 4 beats appear on out1 in order; out0 never valid.
- Backpressure: out1 tready=0 for 5 cycles during a packet -> at most 1 beat held in the register; axis_in_tready=0; held beat stable; no loss or duplication after tready rises.
- Drop: bus_sel=8'h05, 3-beat packet -> axis_in_tready=1 throughout; no output valid; drop_cnt 0->1; 256 further dropped packets -> drop_cnt=8'hFF.
- Back-to-back ports: packet to out0 (last beat stalled by out0 tready=0) followed immediately by a packet to out1 -> out1's first beat loads only in the cycle out0 accepts; no bubble when both ready=1.
- Mid-packet reset: rst_n pulsed low during beat 2 of 4 -> all outputs 0, busy=0; the next beat with bus_sel=128 routes to out0 as a new packet.
